// File: rtl/single_vector_collect_if.sv
// Element stream in, assembled vector out, between an upstream producer and the collector.
// Signals keep the names the summation tree and producer already use.
interface single_vector_collect_if #(
  parameter int WIDTH = 10
);
  logic                   in_valid;
  logic [31:0]            a;
  logic                   in_last;
  logic                   flush;
  logic                   out_valid;
  logic [WIDTH-1:0][31:0] vector_c;
  logic [$clog2(WIDTH+1)-1:0] out_count;
  logic                   out_partial;

  modport master (
    output in_valid, a, in_last, flush,
    input  out_valid, vector_c, out_count, out_partial
  );

  modport slave (
    input  in_valid, a, in_last, flush,
    output out_valid, vector_c, out_count, out_partial
  );
endinterface

// File: rtl/single_vector_collect.sv
// Serial-to-vector collector: packs WIDTH single-precision words into one vector for the
// summation tree, closing early on in_last/flush and padding unused lanes with +0.0.
module single_vector_collect #(
  parameter int WIDTH = 10
) (
  input logic                  clk,
  input logic                  rst,
  single_vector_collect_if.slave bus
);
  localparam int CNTW = $clog2(WIDTH);
  localparam int OCW  = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] CNT_LAST   = CNTW'(WIDTH - 1);
  localparam logic [OCW-1:0]  FULL_COUNT = OCW'(WIDTH);

  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0][31:0] fillBuf_q, fillBuf_d;
  logic [WIDTH-1:0][31:0] vec_q, vec_d;
  logic [OCW-1:0]         count_q, count_d;
  logic                   partial_q, partial_d;
  logic                   valid_q, valid_d;
  logic                   closeData, closeEmpty;

  always_comb begin
    closeData  = bus.in_valid && ((cnt_q == CNT_LAST) || bus.in_last || bus.flush);
    closeEmpty = !bus.in_valid && bus.flush && (cnt_q != '0);

    cnt_d     = cnt_q;
    fillBuf_d = fillBuf_q;
    vec_d     = vec_q;
    count_d   = count_q;
    partial_d = partial_q;
    valid_d   = 1'b0;

    if (closeData) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i < int'(cnt_q)) begin
          vec_d[i] = fillBuf_q[i];
        end else if (i == int'(cnt_q)) begin
          vec_d[i] = bus.a;
        end else begin
          vec_d[i] = '0;
        end
      end
      count_d   = OCW'(cnt_q) + OCW'(1);
      partial_d = (count_d < FULL_COUNT);
      valid_d   = 1'b1;
      cnt_d     = '0;
      fillBuf_d = '0;
    end else if (closeEmpty) begin
      // Lanes at and above cnt are already zero because the buffer is cleared on every close.
      vec_d     = fillBuf_q;
      count_d   = OCW'(cnt_q);
      partial_d = 1'b1;
      valid_d   = 1'b1;
      cnt_d     = '0;
      fillBuf_d = '0;
    end else if (bus.in_valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i == int'(cnt_q)) begin
          fillBuf_d[i] = bus.a;
        end
      end
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      fillBuf_q <= '0;
      vec_q     <= '0;
      count_q   <= '0;
      partial_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      fillBuf_q <= fillBuf_d;
      vec_q     <= vec_d;
      count_q   <= count_d;
      partial_q <= partial_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.vector_c    = vec_q;
  assign bus.out_count   = count_q;
  assign bus.out_partial = partial_q;
endmodule

// File: tb/tb_single_vector_collect.sv
// Bench for single_vector_collect: directed scenarios plus a randomized run, all checked
// every cycle against a queue-based model of how elements group into vectors.
module tb_single_vector_collect;
  localparam int W   = 10;
  localparam int VW  = W * 32;
  localparam int OCW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  single_vector_collect_if #(.WIDTH(W)) bus();
  single_vector_collect #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0]    pending[$];
  logic           expValid;
  logic [VW-1:0]  expVec;
  logic [OCW-1:0] expCount;
  logic           expPartial;

  logic [31:0] ramp[W] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                           32'h41100000, 32'h41200000};

  task automatic checkOutput(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic checkAll(input string ctx);
    checkOutput({ctx, ".valid"},   VW'(bus.out_valid),   VW'(expValid));
    checkOutput({ctx, ".vector"},  bus.vector_c,         expVec);
    checkOutput({ctx, ".count"},   VW'(bus.out_count),   VW'(expCount));
    checkOutput({ctx, ".partial"}, VW'(bus.out_partial), VW'(expPartial));
  endtask

  task automatic modelReset();
    pending.delete();
    expValid   = 1'b0;
    expVec     = '0;
    expCount   = '0;
    expPartial = 1'b0;
  endtask

  task automatic modelClose();
    expVec = '0;
    foreach (pending[i]) expVec[i*32 +: 32] = pending[i];
    expCount   = OCW'(pending.size());
    expPartial = (pending.size() < W);
    expValid   = 1'b1;
    pending.delete();
  endtask

  task automatic modelEdge(input logic v, input logic [31:0] d, input logic l, input logic f);
    expValid = 1'b0;
    if (v) begin
      pending.push_back(d);
      if (pending.size() == W || l || f) modelClose();
    end else if (f && pending.size() > 0) begin
      modelClose();
    end
  endtask

  task automatic applyStimulus(input string ctx, input logic v, input logic [31:0] d,
                               input logic l, input logic f);
    bus.in_valid = v;
    bus.a        = d;
    bus.in_last  = l;
    bus.flush    = f;
    @(posedge clk);
    modelEdge(v, d, l, f);
    #1;
    checkAll(ctx);
  endtask

  task automatic idle(input string ctx, input int n);
    for (int i = 0; i < n; i++) applyStimulus(ctx, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Reset raised between edges must clear the outputs before any clock edge arrives.
  task automatic asyncReset(input string ctx);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.flush    = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll(ctx);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.in_last  = 1'b0;
    bus.flush    = 1'b0;
    modelReset();
    #1;
    checkAll("reset");
    #11;
    rst = 1'b0;

    for (int i = 0; i < W; i++) applyStimulus("ramp", 1'b1, ramp[i], 1'b0, 1'b0);
    idle("ramp_idle", 2);

    for (int i = 0; i < 3 * W; i++) applyStimulus("stream", 1'b1, $urandom, 1'b0, 1'b0);
    idle("stream_idle", 1);

    for (int i = 0; i < 3; i++) applyStimulus("last", 1'b1, $urandom, (i == 2), 1'b0);
    applyStimulus("flush_empty", 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus("last_in_idle", 1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) applyStimulus("flush4", 1'b1, $urandom, 1'b0, 1'b0);
    idle("flush4_idle", 2);
    applyStimulus("flush4_close", 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus("flush5", 1'b1, $urandom, 1'b0, (i == 4));
    applyStimulus("flush5_after", 1'b0, 32'h0, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) applyStimulus("pre_reset", 1'b1, $urandom, 1'b0, 1'b0);
    asyncReset("mid_reset");
    for (int i = 0; i < W; i++) applyStimulus("post_reset", 1'b1, ramp[i], 1'b0, 1'b0);

    for (int i = 0; i < W; i++) applyStimulus("ones", 1'b1, 32'h3F800000, 1'b0, 1'b0);
    applyStimulus("pair", 1'b1, 32'h40000000, 1'b0, 1'b0);
    applyStimulus("pair", 1'b1, 32'h40400000, 1'b1, 1'b0);
    applyStimulus("pair_next", 1'b1, 32'h3F800000, 1'b1, 1'b0);
    idle("pair_idle", 1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        asyncReset("rand_reset");
      end else begin
        applyStimulus("random", ($urandom_range(3) != 0), $urandom,
                      ($urandom_range(9) == 0), ($urandom_range(19) == 0));
      end
    end
    idle("final", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
